spi_reg_bridge: RTL and testbench



---
 rtl/spi_reg_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 target that turns 2-byte frames (command + data) into single
// register-bank reads or writes. The read result is shifted back on MISO.
`timescale 1ns/1ps

module spi_reg_bridge #(
    parameter int REG_W       = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_rdn,
    output logic [ADDR_W-1:0] addr,
    output logic [REG_W-1:0]  wdata,
    output logic              we,
    input  logic [REG_W-1:0]  rdata,
    input  logic              ack,
    input  logic              err,
    output logic              err_flag
);

    localparam int RX_W  = (REG_W > 8) ? REG_W : 8;
    localparam int CNT_W = $clog2(RX_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD_REQ,
        DATA,
        WR_REQ,
        WAIT_CS
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] csSync_q, sclkSync_q, mosiSync_q;
    logic                   csDly_q, sclkDly_q;
    logic                   csLvl, sclkLvl, mosiLvl;
    logic                   csFall, csRise, sclkRise, sclkFall;

    logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
    logic [RX_W-1:0]   rx_q, rx_d, rxNext;
    logic [REG_W-1:0]  tx_q, tx_d;
    logic              txValid_q, txValid_d;
    logic              wrRdn_q, wrRdn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0]  wdata_q, wdata_d;
    logic              errFlag_q, errFlag_d;
    logic              abort, lastCmdBit, lastDataBit;

    // CS synchroniser resets to the deasserted level so reset release never looks like a CS edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            csSync_q   <= '1;
            sclkSync_q <= '0;
            mosiSync_q <= '0;
            csDly_q    <= 1'b1;
            sclkDly_q  <= 1'b0;
        end else begin
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], spi_sclk};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], spi_mosi};
            csDly_q    <= csSync_q[SYNC_STAGES-1];
            sclkDly_q  <= sclkSync_q[SYNC_STAGES-1];
        end
    end

    assign csLvl    = csSync_q[SYNC_STAGES-1];
    assign sclkLvl  = sclkSync_q[SYNC_STAGES-1];
    assign mosiLvl  = mosiSync_q[SYNC_STAGES-1];
    assign csFall   = csDly_q & ~csLvl;
    assign csRise   = ~csDly_q & csLvl;
    assign sclkRise = ~sclkDly_q & sclkLvl;
    assign sclkFall = sclkDly_q & ~sclkLvl;

    assign rxNext      = {rx_q[RX_W-2:0], mosiLvl};
    assign abort       = csRise | ~ena;
    assign lastCmdBit  = (bitCnt_q == CNT_W'(7));
    assign lastDataBit = (bitCnt_q == CNT_W'(REG_W - 1));

    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        txValid_d = txValid_q;
        wrRdn_d   = wrRdn_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        errFlag_d = errFlag_q;

        case (state_q)
            IDLE: begin
                if (ena && csFall) begin
                    state_d   = CMD;
                    bitCnt_d  = '0;
                    rx_d      = '0;
                    tx_d      = '0;
                    errFlag_d = 1'b0;
                end
            end

            CMD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sclkRise) begin
                    rx_d     = rxNext;
                    bitCnt_d = bitCnt_q + CNT_W'(1);
                    if (lastCmdBit) begin
                        bitCnt_d = '0;
                        wrRdn_d  = rxNext[7];
                        addr_d   = rxNext[ADDR_W-1:0];
                        state_d  = rxNext[7] ? DATA : RD_REQ;
                    end
                end
            end

            // A missing ack by the last command falling edge would leave MISO without setup time,
            // so the byte is sent as zeros and the error is flagged instead.
            RD_REQ: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (ack) begin
                    tx_d      = err ? '0 : rdata;
                    txValid_d = 1'b1;
                    if (err) begin
                        errFlag_d = 1'b1;
                    end
                    state_d = DATA;
                end else if (sclkFall) begin
                    errFlag_d = 1'b1;
                    txValid_d = 1'b0;
                    state_d   = DATA;
                end
            end

            // The falling edge that closes the command byte must not shift, or the MSB is lost.
            DATA: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (sclkFall && (bitCnt_q != '0)) begin
                        tx_d = {tx_q[REG_W-2:0], 1'b0};
                    end
                    if (sclkRise) begin
                        rx_d     = rxNext;
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                        if (lastDataBit) begin
                            bitCnt_d = '0;
                            if (wrRdn_q) begin
                                wdata_d = rxNext[REG_W-1:0];
                                state_d = WR_REQ;
                            end else begin
                                state_d = WAIT_CS;
                            end
                        end
                    end
                end
            end

            WR_REQ: begin
                if (ack) begin
                    if (err) begin
                        errFlag_d = 1'b1;
                    end
                    state_d = (csLvl || !ena) ? IDLE : WAIT_CS;
                end
            end

            WAIT_CS: begin
                if (abort) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        if (state_d != DATA) begin
            txValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            txValid_q <= 1'b0;
            wrRdn_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            errFlag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            txValid_q <= txValid_d;
            wrRdn_q   <= wrRdn_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            errFlag_q <= errFlag_d;
        end
    end

    assign spi_miso    = (state_q == DATA) && txValid_q && tx_q[REG_W-1];
    assign spi_miso_oe = ~csLvl;
    assign wr_rdn      = wrRdn_q;
    assign addr        = addr_q;
    assign wdata       = wdata_q;
    assign we          = (state_q == WR_REQ);
    assign err_flag    = errFlag_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: SPI master tasks, a small register bank model,
// a vector table of frames and a write scoreboard fed at stimulus time.
`timescale 1ns/1ps

module tb_spi_reg_bridge;

    localparam int HALF = 8;
    localparam int NV   = 10;

    logic       clk = 1'b0;
    logic       rstb, ena, spi_cs_n, spi_sclk, spi_mosi;
    logic       spi_miso, spi_miso_oe, wr_rdn, we, ack, err, err_flag;
    logic [6:0] addr;
    logic [7:0] wdata, rdata;

    logic       ackTie, errDrive;
    logic [7:0] bankMem [128];
    logic       bankInit = 1'b0;

    int checks = 0;
    int failures = 0;
    int weHighCount = 0;

    typedef struct {
        bit         isWrite;
        logic [7:0] cmd;
        logic [7:0] data;
        bit         errIn;
        logic [7:0] expMiso;
        bit         expErr;
    } vec_t;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    vec_t       vecs [NV];
    wr_t        expWrQ [$];
    logic [7:0] expRdQ [$];
    wr_t        popWr;

    always #5 clk = ~clk;

    assign ack   = ackTie;
    assign err   = errDrive;
    assign rdata = bankMem[addr];

    spi_reg_bridge #(.REG_W(8), .ADDR_W(7), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstb(rstb), .ena(ena),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wr_rdn(wr_rdn), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .ack(ack), .err(err), .err_flag(err_flag)
    );

    // Register bank: preloaded on the first clock, then written by acked, error-free writes.
    always @(posedge clk) begin
        if (!bankInit) begin
            for (int k = 0; k < 128; k++) bankMem[k] <= 8'h00;
            bankMem[5]   <= 8'h3C;
            bankMem[127] <= 8'h99;
            bankInit     <= 1'b1;
        end else if (we && ack && !err) begin
            bankMem[addr] <= wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (we === 1'b1) weHighCount++;
        if (we === 1'b1 && ack === 1'b1) begin
            if (expWrQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write actual=addr 0x%0h data 0x%0h expected=no write", addr, wdata);
            end else begin
                popWr = expWrQ.pop_front();
                checkOutput("wr_addr", 32'(addr), 32'(popWr.addr));
                checkOutput("wr_data", 32'(wdata), 32'(popWr.data));
                checkOutput("wr_wr_rdn", 32'(wr_rdn), 32'd1);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input int nBits,
                                 input bit releaseCs, output logic [7:0] misoByte);
        logic [15:0] frame;
        frame    = {b0, b1};
        misoByte = '0;
        @(negedge clk);
        spi_cs_n = 1'b0;
        for (int i = 0; i < nBits; i++) begin
            spi_mosi = frame[15 - i];
            repeat (HALF) @(negedge clk);
            if (i >= 8) misoByte = {misoByte[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
        repeat (HALF) @(negedge clk);
        if (releaseCs) begin
            spi_cs_n = 1'b1;
            repeat (4 * HALF) @(negedge clk);
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        logic [7:0] rxByte, expByte;
        int         weBefore;
        wr_t        w;
        errDrive = v.errIn;
        if (v.isWrite) begin
            w.addr = v.cmd[6:0];
            w.data = v.data;
            expWrQ.push_back(w);
        end else begin
            expRdQ.push_back(v.expMiso);
        end
        weBefore = weHighCount;
        applyStimulus(v.cmd, v.data, 16, 1'b1, rxByte);
        if (!v.isWrite) begin
            expByte = expRdQ.pop_front();
            checkOutput({tag, "_miso"}, 32'(rxByte), 32'(expByte));
            checkOutput({tag, "_rd_addr"}, 32'(addr), 32'(v.cmd[6:0]));
            checkOutput({tag, "_rd_wr_rdn"}, 32'(wr_rdn), 32'd0);
        end
        checkOutput({tag, "_we_cycles"}, 32'(weHighCount - weBefore), (v.isWrite && ackTie) ? 32'd1 : 32'd0);
        checkOutput({tag, "_err_flag"}, 32'(err_flag), 32'(v.expErr));
        errDrive = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rxByte;
        int         weBefore;

        rstb     = 1'b0;
        ena      = 1'b1;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        ackTie   = 1'b1;
        errDrive = 1'b0;

        vecs[0] = '{1'b1, 8'h83, 8'hA5, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h05, 8'h00, 1'b0, 8'h3C, 1'b0};
        vecs[2] = '{1'b1, 8'h81, 8'h11, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 8'h01, 8'h00, 1'b0, 8'h11, 1'b0};
        vecs[4] = '{1'b0, 8'h03, 8'h00, 1'b0, 8'hA5, 1'b0};
        vecs[5] = '{1'b1, 8'hFF, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 8'h7F, 8'h00, 1'b0, 8'h99, 1'b0};
        vecs[7] = '{1'b1, 8'hA2, 8'hC3, 1'b0, 8'h00, 1'b0};
        vecs[8] = '{1'b0, 8'h22, 8'h00, 1'b0, 8'hC3, 1'b0};
        vecs[9] = '{1'b0, 8'h05, 8'h00, 1'b1, 8'h00, 1'b1};

        repeat (3) @(negedge clk);
        checkOutput("rst_miso", 32'(spi_miso), 32'd0);
        checkOutput("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
        checkOutput("rst_wr_rdn", 32'(wr_rdn), 32'd0);
        checkOutput("rst_addr", 32'(addr), 32'd0);
        checkOutput("rst_wdata", 32'(wdata), 32'd0);
        checkOutput("rst_we", 32'(we), 32'd0);
        checkOutput("rst_err_flag", 32'(err_flag), 32'd0);
        rstb = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < NV; i++) runVector(vecs[i], $sformatf("v%0d", i));

        // err_flag survives CS high and clears on the next CS falling edge
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        checkOutput("errclr_err_flag", 32'(err_flag), 32'd0);
        checkOutput("errclr_miso_oe", 32'(spi_miso_oe), 32'd1);
        spi_cs_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);

        // frame aborted after 12 bits, then a full write and readback
        weBefore = weHighCount;
        applyStimulus(8'h84, 8'hF0, 12, 1'b1, rxByte);
        checkOutput("abort_we_cycles", 32'(weHighCount - weBefore), 32'd0);
        checkOutput("abort_miso_oe", 32'(spi_miso_oe), 32'd0);
        runVector('{1'b1, 8'h84, 8'h6D, 1'b0, 8'h00, 1'b0}, "abort_wr");
        runVector('{1'b0, 8'h04, 8'h00, 1'b0, 8'h6D, 1'b0}, "abort_rd");

        // read with no ack before the last command falling edge
        ackTie = 1'b0;
        runVector('{1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 1'b1}, "slowack");
        ackTie = 1'b1;

        // write ack delayed past CS release: we held, then exactly one write
        ackTie = 1'b0;
        popWr.addr = 7'h0A;
        popWr.data = 8'h3E;
        expWrQ.push_back(popWr);
        applyStimulus(8'h8A, 8'h3E, 16, 1'b1, rxByte);
        checkOutput("late_we_held", 32'(we), 32'd1);
        checkOutput("late_wr_rdn", 32'(wr_rdn), 32'd1);
        @(posedge clk);
        #1 ackTie = 1'b1;
        for (int k = 0; k < 20 && we; k++) @(negedge clk);
        checkOutput("late_we_drop", 32'(we), 32'd0);
        runVector('{1'b0, 8'h0A, 8'h00, 1'b0, 8'h3E, 1'b0}, "late_rd");

        // ena low: frame ignored entirely
        ena = 1'b0;
        weBefore = weHighCount;
        applyStimulus(8'h8B, 8'hEE, 16, 1'b1, rxByte);
        checkOutput("ena_we_cycles", 32'(weHighCount - weBefore), 32'd0);
        ena = 1'b1;
        runVector('{1'b0, 8'h0B, 8'h00, 1'b0, 8'h00, 1'b0}, "ena_rd");

        // async reset while a write waits for ack
        ackTie = 1'b0;
        applyStimulus(8'h90, 8'h77, 16, 1'b0, rxByte);
        checkOutput("rstwr_we_before", 32'(we), 32'd1);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        checkOutput("rstwr_we", 32'(we), 32'd0);
        checkOutput("rstwr_wr_rdn", 32'(wr_rdn), 32'd0);
        checkOutput("rstwr_addr", 32'(addr), 32'd0);
        checkOutput("rstwr_wdata", 32'(wdata), 32'd0);
        checkOutput("rstwr_err_flag", 32'(err_flag), 32'd0);
        checkOutput("rstwr_miso_oe", 32'(spi_miso_oe), 32'd0);
        spi_cs_n = 1'b1;
        ackTie   = 1'b1;
        repeat (4) @(negedge clk);
        rstb = 1'b1;
        repeat (5) @(negedge clk);
        runVector('{1'b1, 8'h91, 8'h42, 1'b0, 8'h00, 1'b0}, "post_rst_wr");
        runVector('{1'b0, 8'h11, 8'h00, 1'b0, 8'h42, 1'b0}, "post_rst_rd");
        runVector('{1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0}, "post_rst_nowr");

        checkOutput("wr_queue_empty", 32'(expWrQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
